// File: rtl/peadder_sched_if.sv
// rtl/peadder_sched_if.sv - handshake bundle between the PE adder sequencer and its datapath
//   master (sequencer): drives pe_ready, adder_in_valid, adder_clr, fmap_valid, fmap_ch;
//                       samples pe_valid, out_ready
//   slave  (datapath) : the mirror image
interface peadder_sched_if #(
    parameter int CH_W = 8
);
    logic            pe_valid;
    logic            pe_ready;
    logic            adder_in_valid;
    logic            adder_clr;
    logic            out_ready;
    logic            fmap_valid;
    logic [CH_W-1:0] fmap_ch;

    modport master (
        input  pe_valid,
        input  out_ready,
        output pe_ready,
        output adder_in_valid,
        output adder_clr,
        output fmap_valid,
        output fmap_ch
    );

    modport slave (
        output pe_valid,
        output out_ready,
        input  pe_ready,
        input  adder_in_valid,
        input  adder_clr,
        input  fmap_valid,
        input  fmap_ch
    );
endinterface

// File: rtl/peadder_sched.sv
// rtl/peadder_sched.sv - sequencing controller for the sparse-CNN PE adder (accumulator) stage
//   clk, rst             : clock, synchronous active-high reset
//   start                : job start, sampled only while idle
//   num_batches          : PE batches per channel, latched on start
//   num_channels         : channels per job, latched on start
//   bus (master)         : pe_valid/pe_ready upstream, adder_in_valid/adder_clr to the
//                          accumulator, fmap_valid/fmap_ch/out_ready downstream
//   busy                 : high whenever a job is in flight (including the done cycle)
//   done                 : one-cycle pulse at job end
module peadder_sched #(
    parameter int BATCH_W = 8,
    parameter int CH_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BATCH_W-1:0] num_batches,
    input  logic [CH_W-1:0]    num_channels,
    peadder_sched_if.master    bus,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [BATCH_W-1:0] nb_q, nb_d;
    logic [CH_W-1:0]    nc_q, nc_d;
    logic [BATCH_W-1:0] batch_cnt_q, batch_cnt_d;
    logic [CH_W-1:0]    ch_idx_q, ch_idx_d;

    logic               pe_ready_q, pe_ready_d;
    logic               adder_clr_q, adder_clr_d;
    logic               fmap_valid_q, fmap_valid_d;
    logic [CH_W-1:0]    fmap_ch_q, fmap_ch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               last_batch;
    logic               last_ch;

    // The adder samples in the same cycle as the handshake, so this stays combinational.
    assign accept     = bus.pe_valid & (state_q == S_ACCUM);

    // Equality against the latched counts; counts are nonzero whenever these are used.
    assign last_batch = (batch_cnt_q == nb_q - BATCH_W'(1));
    assign last_ch    = (ch_idx_q == nc_q - CH_W'(1));

    always_comb begin
        state_d     = state_q;
        nb_d        = nb_q;
        nc_d        = nc_q;
        batch_cnt_d = batch_cnt_q;
        ch_idx_d    = ch_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((num_batches != '0) && (num_channels != '0)) begin
                        nb_d        = num_batches;
                        nc_d        = num_channels;
                        batch_cnt_d = '0;
                        ch_idx_d    = '0;
                        state_d     = S_CLEAR;
                    end else begin
                        // Degenerate job: finish without touching the accumulator.
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                batch_cnt_d = '0;
                state_d     = S_ACCUM;
            end
            S_ACCUM: begin
                if (accept) begin
                    batch_cnt_d = batch_cnt_q + BATCH_W'(1);
                    if (last_batch) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // One idle cycle lets the accumulator register absorb the final batch.
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    if (last_ch) begin
                        state_d = S_DONE;
                    end else begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                        state_d  = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they line up with state_q.
        pe_ready_d   = (state_d == S_ACCUM);
        adder_clr_d  = (state_d == S_CLEAR);
        fmap_valid_d = (state_d == S_EMIT);
        fmap_ch_d    = ch_idx_d;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nb_q         <= '0;
            nc_q         <= '0;
            batch_cnt_q  <= '0;
            ch_idx_q     <= '0;
            pe_ready_q   <= 1'b0;
            adder_clr_q  <= 1'b0;
            fmap_valid_q <= 1'b0;
            fmap_ch_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            nb_q         <= nb_d;
            nc_q         <= nc_d;
            batch_cnt_q  <= batch_cnt_d;
            ch_idx_q     <= ch_idx_d;
            pe_ready_q   <= pe_ready_d;
            adder_clr_q  <= adder_clr_d;
            fmap_valid_q <= fmap_valid_d;
            fmap_ch_q    <= fmap_ch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.pe_ready       = pe_ready_q;
    assign bus.adder_in_valid = accept;
    assign bus.adder_clr      = adder_clr_q;
    assign bus.fmap_valid     = fmap_valid_q;
    assign bus.fmap_ch        = fmap_ch_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_peadder_sched.sv
// tb/tb_peadder_sched.sv - self-checking bench for peadder_sched
module tb_peadder_sched;
    localparam int BW   = 8;
    localparam int CW   = 8;
    localparam int MAXC = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] num_batches;
    logic [CW-1:0] num_channels;
    logic          busy;
    logic          done;

    peadder_sched_if #(.CH_W(CW)) bus ();

    peadder_sched #(.BATCH_W(BW), .CH_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_batches  (num_batches),
        .num_channels (num_channels),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Input patterns per cycle of a job (cycle 0 = start cycle).
    bit pv  [MAXC];
    bit orr [MAXC];

    // Expected per-cycle outputs, derived from the job-level timing rules.
    bit e_pr [MAXC];
    bit e_iv [MAXC];
    bit e_clr[MAXC];
    bit e_fv [MAXC];
    bit e_bsy[MAXC];
    bit e_dn [MAXC];
    int e_ch [MAXC];

    int obs_iv, obs_clr, obs_done, obs_done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: always 1, 1: 1,0,1,0 from the first ACCUM cycle, 2: random (~2/3 high)
    task automatic set_pat(input int pv_mode, input int or_mode);
        for (int k = 0; k < MAXC; k++) begin
            pv[k]  = (pv_mode == 0) ? 1'b1 : (pv_mode == 1) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
            orr[k] = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
        end
    endtask

    // Walk the job: each channel is CLEAR, then ACCUM until nb batches are seen on
    // pv, one DRAIN cycle, then EMIT until out_ready; DONE follows the last channel.
    task automatic build(input int nb, input int nc, output int len);
        int c, s, acc;
        for (int k = 0; k < MAXC; k++) begin
            e_pr[k] = 0; e_iv[k] = 0; e_clr[k] = 0; e_fv[k] = 0;
            e_bsy[k] = 0; e_dn[k] = 0; e_ch[k] = 0;
        end
        if (nb == 0 || nc == 0) begin
            e_bsy[1] = 1; e_dn[1] = 1; len = 1;
            return;
        end
        s = 1;
        for (int ch = 0; ch < nc; ch++) begin
            e_clr[s] = 1; e_bsy[s] = 1;
            c   = s + 1;
            acc = 0;
            while (acc < nb && c < MAXC - 4) begin
                e_pr[c] = 1; e_bsy[c] = 1;
                if (pv[c]) begin
                    e_iv[c] = 1;
                    acc++;
                end
                c++;
            end
            e_bsy[c] = 1;
            c++;
            while (c < MAXC - 4) begin
                e_fv[c] = 1; e_ch[c] = ch; e_bsy[c] = 1;
                if (orr[c]) break;
                c++;
            end
            s = c + 1;
        end
        chk("sched_fits", 32'(s < MAXC - 4), 32'd1);
        e_dn[s] = 1; e_bsy[s] = 1;
        len = s;
    endtask

    task automatic run_job(input string tag, input int nb, input int nc, input int sb, input int rst_at);
        int          len, last;
        logic [31:0] o, x;
        build(nb, nc, len);
        last = (rst_at >= 0) ? rst_at + 2 : len + 2;
        obs_iv = 0; obs_clr = 0; obs_done = 0; obs_done_cyc = -1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            rst   = (k == rst_at);
            start = (k == 0) || (k == sb);
            if (k == 0) begin
                num_batches  = BW'(nb);
                num_channels = CW'(nc);
            end else if (k == sb) begin
                num_batches  = BW'(nb + 3);
                num_channels = CW'(nc + 1);
            end else begin
                num_batches  = BW'($urandom);
                num_channels = CW'($urandom);
            end
            bus.pe_valid  = pv[k];
            bus.out_ready = orr[k];
            @(negedge clk);
            if (rst_at >= 0 && k > rst_at)
                x = '0;
            else
                x = {18'b0, e_pr[k], e_iv[k], e_clr[k], e_fv[k],
                     (e_fv[k] ? CW'(e_ch[k]) : CW'(0)), e_bsy[k], e_dn[k]};
            o = {18'b0, bus.pe_ready, bus.adder_in_valid, bus.adder_clr, bus.fmap_valid,
                 (x[CW+2] ? bus.fmap_ch : CW'(0)), busy, done};
            chk($sformatf("%s_cyc%0d", tag, k), o, x);
            if (bus.adder_in_valid) obs_iv++;
            if (bus.adder_clr) obs_clr++;
            if (done) begin
                obs_done++;
                obs_done_cyc = k;
            end
        end
        if (rst_at < 0) begin
            chk({tag, "_in_valid_cnt"}, obs_iv, nb * nc);
            chk({tag, "_clr_cnt"}, obs_clr, (nb == 0) ? 0 : nc);
            chk({tag, "_done_cnt"}, obs_done, 1);
        end else begin
            chk({tag, "_done_cnt"}, obs_done, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_batches = '0; num_channels = '0;
        bus.pe_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {18'b0, bus.pe_ready, bus.adder_in_valid, bus.adder_clr, bus.fmap_valid, bus.fmap_ch, busy, done},
            32'd0);

        // Single job, no stalls: done lands at t+13.
        set_pat(0, 0);
        run_job("single", 3, 2, -1, -1);
        chk("single_done_cycle", obs_done_cyc, 13);

        // Upstream bubbles.
        set_pat(1, 0);
        run_job("bubbles", 4, 1, -1, -1);

        // Downstream stall of 5 cycles at the first EMIT (t+5 .. t+9).
        set_pat(0, 0);
        for (int k = 5; k <= 9; k++) orr[k] = 1'b0;
        run_job("stall", 2, 2, -1, -1);

        // Zero counts.
        set_pat(2, 2);
        run_job("zero_nb", 0, 3, -1, -1);
        chk("zero_nb_done_cycle", obs_done_cyc, 1);
        run_job("zero_nc", 2, 0, -1, -1);
        chk("zero_nc_done_cycle", obs_done_cyc, 1);

        // Reset after 2 of 5 batches, then a full job.
        set_pat(0, 0);
        pv[4] = 1'b0;
        run_job("rst_mid", 5, 1, -1, 4);
        set_pat(0, 0);
        run_job("after_rst", 5, 2, -1, -1);

        // Start while busy (in ACCUM) with different counts is ignored.
        set_pat(0, 0);
        run_job("busy_start", 3, 2, 3, -1);

        // Random traffic.
        for (int i = 0; i < 8; i++) begin
            set_pat(2, 2);
            run_job($sformatf("rand%0d", i), $urandom_range(1, 8), $urandom_range(1, 4), -1, -1);
        end

        // Maximum counts.
        set_pat(0, 0);
        run_job("nb_max", 255, 1, -1, -1);
        run_job("nc_max", 1, 255, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
